// File: rtl/imem_fetch_arbiter_pkg.sv
// imem_arb_pkg: shared encodings for the instruction-memory fetch arbiter.
// Holds the FSM state encoding, the requester ids and the constants used
// by the address-error check.
package imem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_DBG   = 1'b1;

   // Wait-state counter width; WAIT_CYC must fit in it (0..15).
   localparam int unsigned CNT_W = 4;

   // Instructions are word aligned: the low ALIGN_BITS of an address must be zero.
   localparam int unsigned ALIGN_BITS = 2;

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// imem_fetch_arbiter_if: requester handshakes plus the InstructionMemory port.
// The slave modport is the arbiter; the master modport is the environment
// (fetch/debug requesters and the memory itself).
interface imem_fetch_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 32
);
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_gnt;
   logic              fetch_rvalid;
   logic [DATA_W-1:0] fetch_rdata;
   logic              fetch_err;

   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_err;

   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_data;
   logic              busy;

   modport slave (
      input  fetch_req, fetch_addr, dbg_req, dbg_addr, imem_data,
      output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
      output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
      output imem_addr, busy
   );

   modport master (
      output fetch_req, fetch_addr, dbg_req, dbg_addr, imem_data,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
      input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
      input  imem_addr, busy
   );
endinterface

// File: rtl/imem_fetch_arbiter_pick.sv
// imem_arb_pick: chooses which requester gets the memory port.
// Default build: fixed priority, debug beats fetch.
// With IMEM_ARB_RR_EN defined: round robin, a tie goes to the requester that
// was not granted last; the pointer moves on every grant.
module imem_arb_pick
   import imem_arb_pkg::*;
(
   input  logic CLK,
   input  logic resetl,
   input  logic fetch_req,
   input  logic dbg_req,
   input  logic take,
   output logic any_req,
   output logic pick_id
);

   assign any_req = fetch_req | dbg_req;

`ifdef IMEM_ARB_RR_EN
   logic last_q;
   logic last_d;

   // Tie goes to whoever was not granted last; a lone requester always wins.
   always_comb begin
      if (fetch_req && dbg_req) begin
         pick_id = ~last_q;
      end else begin
         pick_id = dbg_req ? REQ_DBG : REQ_FETCH;
      end
      last_d = take ? pick_id : last_q;
   end

   // Remember the most recent winner; starts out pointing at fetch.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         last_q <= REQ_FETCH;
      end else begin
         last_q <= last_d;
      end
   end
`else
   logic unused_pick;
   assign unused_pick = CLK ^ resetl ^ take;
   assign pick_id     = dbg_req ? REQ_DBG : REQ_FETCH;
`endif

endmodule

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: shares the single read-only InstructionMemory port
// between core fetch and debug readback, inserting WAIT_CYC+1 wait cycles
// per good read and answering bad addresses with an error response.
// Optional macro IMEM_ARB_RR_EN selects round-robin arbitration.
module imem_fetch_arbiter
   import imem_arb_pkg::*;
#(
   parameter int unsigned WAIT_CYC  = 2,
   parameter int unsigned MEM_BYTES = 160,
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned DATA_W    = 32
)(
   input logic                 CLK,
   input logic                 resetl,
   imem_fetch_arbiter_if.slave bus
);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              win_q, win_d;
   logic              bad_q, bad_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic              fetch_gnt_q, fetch_gnt_d;
   logic              dbg_gnt_q, dbg_gnt_d;
   logic              fetch_rvalid_q, fetch_rvalid_d;
   logic              dbg_rvalid_q, dbg_rvalid_d;
   logic              fetch_err_q, fetch_err_d;
   logic              dbg_err_q, dbg_err_d;
   logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              busy_q, busy_d;

   logic              any_req;
   logic              pick_id;
   logic              take;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_bad;

   assign take     = (state_q == IDLE) && any_req;
   assign sel_addr = (pick_id == REQ_DBG) ? bus.dbg_addr : bus.fetch_addr;
   assign sel_bad  = (sel_addr[ALIGN_BITS-1:0] != '0) ||
                     (sel_addr >= ADDR_W'(MEM_BYTES));

   imem_arb_pick u_pick (
      .CLK       (CLK),
      .resetl    (resetl),
      .fetch_req (bus.fetch_req),
      .dbg_req   (bus.dbg_req),
      .take      (take),
      .any_req   (any_req),
      .pick_id   (pick_id)
   );

   // Next-state logic: accept in IDLE, count wait states, then emit one response pulse.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      win_d          = win_q;
      bad_d          = bad_q;
      imem_addr_d    = imem_addr_q;
      buf_d          = buf_q;
      fetch_gnt_d    = 1'b0;
      dbg_gnt_d      = 1'b0;
      fetch_rvalid_d = 1'b0;
      dbg_rvalid_d   = 1'b0;
      fetch_err_d    = 1'b0;
      dbg_err_d      = 1'b0;
      fetch_rdata_d  = fetch_rdata_q;
      dbg_rdata_d    = dbg_rdata_q;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               win_d       = pick_id;
               imem_addr_d = sel_addr;
               bad_d       = sel_bad;
               fetch_gnt_d = (pick_id == REQ_FETCH);
               dbg_gnt_d   = (pick_id == REQ_DBG);
               if (sel_bad) begin
                  buf_d   = '0;
                  state_d = RESP;
               end else begin
                  cnt_d   = CNT_W'(WAIT_CYC);
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               buf_d   = bus.imem_data;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
            if (win_q == REQ_DBG) begin
               dbg_rvalid_d = 1'b1;
               dbg_err_d    = bad_q;
               dbg_rdata_d  = buf_q;
            end else begin
               fetch_rvalid_d = 1'b1;
               fetch_err_d    = bad_q;
               fetch_rdata_d  = buf_q;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset also abandons any read in flight.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         win_q          <= REQ_FETCH;
         bad_q          <= 1'b0;
         imem_addr_q    <= '0;
         buf_q          <= '0;
         fetch_gnt_q    <= 1'b0;
         dbg_gnt_q      <= 1'b0;
         fetch_rvalid_q <= 1'b0;
         dbg_rvalid_q   <= 1'b0;
         fetch_err_q    <= 1'b0;
         dbg_err_q      <= 1'b0;
         fetch_rdata_q  <= '0;
         dbg_rdata_q    <= '0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         win_q          <= win_d;
         bad_q          <= bad_d;
         imem_addr_q    <= imem_addr_d;
         buf_q          <= buf_d;
         fetch_gnt_q    <= fetch_gnt_d;
         dbg_gnt_q      <= dbg_gnt_d;
         fetch_rvalid_q <= fetch_rvalid_d;
         dbg_rvalid_q   <= dbg_rvalid_d;
         fetch_err_q    <= fetch_err_d;
         dbg_err_q      <= dbg_err_d;
         fetch_rdata_q  <= fetch_rdata_d;
         dbg_rdata_q    <= dbg_rdata_d;
         busy_q         <= busy_d;
      end
   end

   assign bus.fetch_gnt    = fetch_gnt_q;
   assign bus.fetch_rvalid = fetch_rvalid_q;
   assign bus.fetch_rdata  = fetch_rdata_q;
   assign bus.fetch_err    = fetch_err_q;
   assign bus.dbg_gnt      = dbg_gnt_q;
   assign bus.dbg_rvalid   = dbg_rvalid_q;
   assign bus.dbg_rdata    = dbg_rdata_q;
   assign bus.dbg_err      = dbg_err_q;
   assign bus.imem_addr    = imem_addr_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb_imem_fetch_arbiter: randomized and directed stimulus for the fetch
// arbiter, checked by a scoreboard fed from a transaction-level model.
// A second instance with WAIT_CYC=0 covers back-to-back fetch timing.
module tb_imem_fetch_arbiter;

   localparam int WAIT_CYC  = 2;
   localparam int MEM_BYTES = 160;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } resp_t;

   logic        CLK;
   logic        resetl;
   logic        f_req, d_req, f0_req;
   logic [63:0] f_addr, d_addr, f0_addr;
   logic [31:0] mem [0:63];

   resp_t       fetch_q[$];
   resp_t       dbg_q[$];
   int          test_count;
   int          fail_count;
   int          cyc;
   int          next_free;
   int          busy_from, busy_until;
   logic        exp_fgnt, exp_dgnt;
   logic        f_granted, d_granted;
   logic        last_who;
   logic        mon_en;
   logic [31:0] last_fdata, last_ddata;
   int          g1, g2, r1, r2;
   logic [31:0] d1, d2;

   imem_fetch_arbiter_if #(.ADDR_W(64), .DATA_W(32)) bus ();
   imem_fetch_arbiter_if #(.ADDR_W(64), .DATA_W(32)) bus0 ();

   assign bus.fetch_req  = f_req;
   assign bus.fetch_addr = f_addr;
   assign bus.dbg_req    = d_req;
   assign bus.dbg_addr   = d_addr;
   assign bus.imem_data  = (bus.imem_addr < 64'(MEM_BYTES)) ? mem[bus.imem_addr[7:2]] : 32'h0;

   assign bus0.fetch_req  = f0_req;
   assign bus0.fetch_addr = f0_addr;
   assign bus0.dbg_req    = 1'b0;
   assign bus0.dbg_addr   = 64'h0;
   assign bus0.imem_data  = (bus0.imem_addr < 64'(MEM_BYTES)) ? mem[bus0.imem_addr[7:2]] : 32'h0;

   imem_fetch_arbiter #(.WAIT_CYC(WAIT_CYC), .MEM_BYTES(MEM_BYTES), .ADDR_W(64), .DATA_W(32)) u_dut (
      .CLK    (CLK),
      .resetl (resetl),
      .bus    (bus)
   );

   imem_fetch_arbiter #(.WAIT_CYC(0), .MEM_BYTES(MEM_BYTES), .ADDR_W(64), .DATA_W(32)) u_dut0 (
      .CLK    (CLK),
      .resetl (resetl),
      .bus    (bus0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
      end
   endtask

   function automatic logic [63:0] randAddr();
      logic [63:0] a;
      case ($urandom_range(0, 9))
         0:       a = {32'($urandom), 32'($urandom)};
         1:       a = 64'($urandom_range(0, 39) * 4 + $urandom_range(1, 3));
         2:       a = 64'(MEM_BYTES) + 64'($urandom_range(0, 15) * 4);
         3:       a = 64'h9C;
         default: a = 64'($urandom_range(0, 39) * 4);
      endcase
      return a;
   endfunction

   // Transaction-level reference: who wins, when the answer is due, what it holds.
   task automatic modelStep();
      logic        who;
      logic [63:0] a;
      logic        bad;
      int          lat;
      resp_t       r;
      cyc++;
      exp_fgnt = 1'b0;
      exp_dgnt = 1'b0;
      if (resetl && cyc >= next_free && (f_req || d_req)) begin
         if (f_req && d_req) begin
`ifdef IMEM_ARB_RR_EN
            who = ~last_who;
`else
            who = 1'b1;
`endif
         end else begin
            who = d_req;
         end
         a      = who ? d_addr : f_addr;
         bad    = (a % 4 != 0) || (a >= 64'(MEM_BYTES));
         lat    = bad ? 1 : WAIT_CYC + 2;
         r.due  = cyc + lat;
         r.data = bad ? 32'h0 : mem[a[7:2]];
         r.err  = bad;
         if (who) begin
            dbg_q.push_back(r);
            exp_dgnt  = 1'b1;
            d_granted = 1'b1;
         end else begin
            fetch_q.push_back(r);
            exp_fgnt  = 1'b1;
            f_granted = 1'b1;
         end
         busy_from  = cyc;
         busy_until = cyc + lat;
         next_free  = cyc + lat + 1;
         last_who   = who;
      end
   endtask

   task automatic modelReset();
      fetch_q.delete();
      dbg_q.delete();
      exp_fgnt   = 1'b0;
      exp_dgnt   = 1'b0;
      f_req      = 1'b0;
      d_req      = 1'b0;
      f_granted  = 1'b0;
      d_granted  = 1'b0;
      next_free  = 0;
      busy_until = 0;
      last_who   = 1'b0;
      last_fdata = 32'h0;
      last_ddata = 32'h0;
   endtask

   task automatic stepCycle();
      @(posedge CLK);
      modelStep();
      @(negedge CLK);
      if (f_granted) begin
         f_req     = 1'b0;
         f_addr    = randAddr();
         f_granted = 1'b0;
      end
      if (d_granted) begin
         d_req     = 1'b0;
         d_addr    = randAddr();
         d_granted = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic use_f, input logic [63:0] fa,
                                input logic use_d, input logic [63:0] da);
      if (use_f) begin
         f_req  = 1'b1;
         f_addr = fa;
      end
      if (use_d) begin
         d_req  = 1'b1;
         d_addr = da;
      end
   endtask

   task automatic randomDrive();
      if (!f_req) begin
         if ($urandom_range(0, 2) == 0) applyStimulus(1'b1, randAddr(), 1'b0, 64'h0);
      end else if ($urandom_range(0, 19) == 0) begin
         f_req = 1'b0;
      end
      if (!d_req) begin
         if ($urandom_range(0, 2) == 0) applyStimulus(1'b0, 64'h0, 1'b1, randAddr());
      end else if ($urandom_range(0, 19) == 0) begin
         d_req = 1'b0;
      end
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while ((f_req || d_req || fetch_q.size() != 0 || dbg_q.size() != 0) && n < budget) begin
         stepCycle();
         n++;
      end
      if (n >= budget)
         checkOutput("drain_timeout", 64'(fetch_q.size() + dbg_q.size()) + 64'(f_req) + 64'(d_req), 64'h0);
      stepCycle();
      stepCycle();
   endtask

   // Monitor: compares every cycle of the main instance against the scoreboard.
   always @(negedge CLK) begin
      resp_t r;
      if (mon_en) begin
         checkOutput("fetch_gnt", 64'(bus.fetch_gnt), 64'(exp_fgnt));
         checkOutput("dbg_gnt", 64'(bus.dbg_gnt), 64'(exp_dgnt));
         checkOutput("busy", 64'(bus.busy), 64'((cyc >= busy_from && cyc < busy_until) ? 1 : 0));
         if (bus.fetch_rvalid) begin
            if (fetch_q.size() == 0) begin
               checkOutput("fetch_rvalid_unexpected", 64'(bus.fetch_rvalid), 64'h0);
            end else begin
               r = fetch_q.pop_front();
               checkOutput("fetch_rvalid_cycle", 64'(cyc), 64'(r.due));
               checkOutput("fetch_rdata", 64'(bus.fetch_rdata), 64'(r.data));
               checkOutput("fetch_err", 64'(bus.fetch_err), 64'(r.err));
               last_fdata = r.data;
            end
         end else begin
            checkOutput("fetch_rdata_hold", 64'(bus.fetch_rdata), 64'(last_fdata));
            if (fetch_q.size() != 0 && fetch_q[0].due <= cyc) begin
               checkOutput("fetch_rvalid_missing", 64'(bus.fetch_rvalid), 64'h1);
               void'(fetch_q.pop_front());
            end
         end
         if (bus.dbg_rvalid) begin
            if (dbg_q.size() == 0) begin
               checkOutput("dbg_rvalid_unexpected", 64'(bus.dbg_rvalid), 64'h0);
            end else begin
               r = dbg_q.pop_front();
               checkOutput("dbg_rvalid_cycle", 64'(cyc), 64'(r.due));
               checkOutput("dbg_rdata", 64'(bus.dbg_rdata), 64'(r.data));
               checkOutput("dbg_err", 64'(bus.dbg_err), 64'(r.err));
               last_ddata = r.data;
            end
         end else begin
            checkOutput("dbg_rdata_hold", 64'(bus.dbg_rdata), 64'(last_ddata));
            if (dbg_q.size() != 0 && dbg_q[0].due <= cyc) begin
               checkOutput("dbg_rvalid_missing", 64'(bus.dbg_rvalid), 64'h1);
               void'(dbg_q.pop_front());
            end
         end
      end
   end

   // Main sequence: directed cases, reset mid-read, random traffic, zero-wait timing.
   initial begin
      test_count = 0;
      fail_count = 0;
      cyc        = 0;
      busy_from  = 0;
      resetl     = 1'b0;
      mon_en     = 1'b0;
      f_addr     = 64'h0;
      d_addr     = 64'h0;
      f0_req     = 1'b0;
      f0_addr    = 64'h0;
      modelReset();
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'hF84003E9;
      mem[1] = 32'hF84083EA;
      mem[5] = 32'hAA0B014A;
      mem[6] = 32'h8A0A018C;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checkOutput("rst_fetch_gnt", 64'(bus.fetch_gnt), 64'h0);
      checkOutput("rst_dbg_rvalid", 64'(bus.dbg_rvalid), 64'h0);
      checkOutput("rst_fetch_rdata", 64'(bus.fetch_rdata), 64'h0);
      checkOutput("rst_imem_addr", bus.imem_addr, 64'h0);
      checkOutput("rst_busy", 64'(bus.busy), 64'h0);
      resetl = 1'b1;
      mon_en = 1'b1;

      applyStimulus(1'b1, 64'h0, 1'b0, 64'h0);
      waitDrain(40);
      applyStimulus(1'b1, 64'h18, 1'b1, 64'h14);
      waitDrain(40);
      applyStimulus(1'b1, 64'h6, 1'b0, 64'h0);
      waitDrain(40);
      applyStimulus(1'b1, 64'hA0, 1'b1, 64'h9C);
      waitDrain(40);
      applyStimulus(1'b0, 64'h0, 1'b1, 64'h1_0000_0004);
      waitDrain(40);

      applyStimulus(1'b0, 64'h0, 1'b1, 64'h20);
      stepCycle();
      stepCycle();
      #2 resetl = 1'b0;
      modelReset();
      #1;
      checkOutput("rst_mid_dbg_gnt", 64'(bus.dbg_gnt), 64'h0);
      checkOutput("rst_mid_dbg_rvalid", 64'(bus.dbg_rvalid), 64'h0);
      checkOutput("rst_mid_dbg_err", 64'(bus.dbg_err), 64'h0);
      checkOutput("rst_mid_dbg_rdata", 64'(bus.dbg_rdata), 64'h0);
      checkOutput("rst_mid_fetch_rdata", 64'(bus.fetch_rdata), 64'h0);
      checkOutput("rst_mid_imem_addr", bus.imem_addr, 64'h0);
      checkOutput("rst_mid_busy", 64'(bus.busy), 64'h0);
      stepCycle();
      stepCycle();
      #2 resetl = 1'b1;
      repeat (8) stepCycle();

      for (int i = 0; i < 600; i++) begin
         randomDrive();
         stepCycle();
      end
      waitDrain(80);

      exp_fgnt = 1'b0;
      exp_dgnt = 1'b0;
      g1 = -1; g2 = -1; r1 = -1; r2 = -1;
      d1 = 32'h0; d2 = 32'h0;
      f0_addr = 64'h0;
      f0_req  = 1'b1;
      for (int t = 1; t <= 40 && r2 < 0; t++) begin
         @(negedge CLK);
         if (bus0.fetch_gnt) begin
            if (g1 < 0) begin
               g1      = t;
               f0_addr = 64'h4;
            end else begin
               g2     = t;
               f0_req = 1'b0;
            end
         end
         if (bus0.fetch_rvalid) begin
            if (r1 < 0) begin
               r1 = t;
               d1 = bus0.fetch_rdata;
            end else begin
               r2 = t;
               d2 = bus0.fetch_rdata;
            end
         end
      end
      f0_req = 1'b0;
      checkOutput("w0_first_latency", 64'(r1 - g1), 64'd2);
      checkOutput("w0_gnt_spacing", 64'(g2 - g1), 64'd3);
      checkOutput("w0_second_latency", 64'(r2 - g2), 64'd2);
      checkOutput("w0_first_data", 64'(d1), 64'hF84003E9);
      checkOutput("w0_second_data", 64'(d2), 64'hF84083EA);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
